// File: rtl/cayde_alu_pkg.sv
// Shared op encoding, FSM state type and width default for the execute-stage ALU.
// The upstream ALU control decoder imports alu_op_t from here so both ends agree.
package cayde_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input alu_op_t op_code);
        return (op_code == OP_SLL) || (op_code == OP_SRL) || (op_code == OP_SRA);
    endfunction

endpackage

// File: rtl/cayde_alu_shifter.sv
// Serial shifter: moves the working register one bit per cycle until the count runs out.
// done is high during the final step so the FSM can register the result on that same edge.
module cayde_alu_shifter
    import cayde_alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  alu_op_t            op_code,
    input  logic [XLEN-1:0]    value,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    shifted
);

    logic [XLEN-1:0]    work_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    alu_op_t            op_reg;

    assign busy = (cnt_reg != '0);
    assign done = (cnt_reg == SHAMT_W'(1));

    always_comb begin
        shifted = work_reg;
        case (op_reg)
            OP_SLL:  shifted = {work_reg[XLEN-2:0], 1'b0};
            OP_SRA:  shifted = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
            default: shifted = {1'b0, work_reg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg <= '0;
            cnt_reg  <= '0;
            op_reg   <= OP_SLL;
        end else if (start) begin
            work_reg <= value;
            cnt_reg  <= shamt;
            op_reg   <= op_code;
        end else if (busy) begin
            work_reg <= shifted;
            cnt_reg  <= cnt_reg - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/cayde_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shifts,
// valid/ready on both sides with the result held until the consumer takes it.
module cayde_alu_exec
    import cayde_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHAMT_W = $clog2(XLEN);

    alu_state_t         state_reg;
    logic [XLEN-1:0]    result_reg;
    logic               zero_reg;
    logic               illegal_reg;

    alu_op_t            op_code;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               shift_start;
    logic [XLEN-1:0]    alu_value;
    logic               alu_illegal;
    logic               sh_busy;
    logic               sh_done;
    logic [XLEN-1:0]    sh_shifted;

    assign op_code     = alu_op_t'(op);
    assign shamt       = b[SHAMT_W-1:0];
    assign accept      = in_valid && (state_reg == ST_IDLE);
    assign shift_start = accept && is_shift_op(op_code) && (shamt != '0);

    // Shifts land here only when shamt is zero, in which case the result is a unchanged.
    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        case (op_code)
            OP_AND:  alu_value = a & b;
            OP_OR:   alu_value = a | b;
            OP_ADD:  alu_value = a + b;
            OP_XOR:  alu_value = a ^ b;
            OP_SUB:  alu_value = a - b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_value = a;
            OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (a < b)};
            default: alu_illegal = 1'b1;
        endcase
    end

    cayde_alu_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (shift_start),
        .op_code (op_code),
        .value   (a),
        .shamt   (shamt),
        .busy    (sh_busy),
        .done    (sh_done),
        .shifted (sh_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (shift_start) begin
                        state_reg <= ST_SHIFT;
                    end else if (accept) begin
                        result_reg  <= alu_value;
                        zero_reg    <= (alu_value == '0);
                        illegal_reg <= alu_illegal;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        result_reg  <= sh_shifted;
                        zero_reg    <= (sh_shifted == '0);
                        illegal_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else if (!sh_busy) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_cayde_alu_exec.sv
// Scoreboard bench for cayde_alu_exec: expectations are queued at drive time and
// popped when the result appears, along with the expected accept-to-valid latency.
module tb_cayde_alu_exec;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      op = 4'd0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    cayde_alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t alu_model(input logic [3:0] m_op, input logic [31:0] ma, input logic [31:0] mb);
        exp_t e;
        int   sh;
        sh    = int'(mb[4:0]);
        e.ill = 1'b0;
        e.lat = 0;
        case (m_op)
            4'd0: e.res = ma & mb;
            4'd1: e.res = ma | mb;
            4'd2: e.res = ma + mb;
            4'd3: e.res = ma ^ mb;
            4'd4: begin e.res = ma << sh; e.lat = sh; end
            4'd5: begin e.res = ma >> sh; e.lat = sh; end
            4'd6: e.res = ma - mb;
            4'd7: begin e.res = $unsigned($signed(ma) >>> sh); e.lat = sh; end
            4'd8: e.res = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            4'd9: e.res = (ma < mb) ? 32'd1 : 32'd0;
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // One transaction: drive, wait for result, compare against the popped expectation.
    task automatic do_op(input string name, input logic [3:0] t_op, input logic [31:0] ta,
                         input logic [31:0] tb_, input logic [31:0] exp_res, input logic exp_ill,
                         input int exp_lat, input int stall);
        exp_t e;
        int   n;
        logic [31:0] held;
        @(negedge clk);
        check_eq({name, "_in_ready_before"}, {31'd0, in_ready}, 32'd1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        op = t_op; a = ta; b = tb_;
        e.res = exp_res; e.ill = exp_ill; e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            check_eq({name, "_timeout"}, 32'(n), 32'(e.lat));
            return;
        end
        check_eq({name, "_latency"}, 32'(n), 32'(e.lat));
        check_eq({name, "_result"}, result, e.res);
        check_eq({name, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
        check_eq({name, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        held = result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq({name, "_hold_result"}, result, held);
            check_eq({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check_eq({name, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq({name, "_back_to_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h ill=%0d lat=%0d",
                 name, t_op, ta, tb_, held, exp_ill, n);
    endtask

    initial begin
        exp_t m;
        logic [3:0]  r_op;
        logic [31:0] ra, rb;
        int vcount;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_state", {28'd0, in_ready, out_valid, zero, illegal}, 32'b1010);
        check_eq("reset_result", result, 32'd0);
        $display("txn reset in_ready=%0d out_valid=%0d result=0x%08h", in_ready, out_valid, result);

        do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 0);
        do_op("sub_neg", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 0);
        do_op("slt", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, 0);
        do_op("sltu", 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 0);
        do_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31, 0);
        do_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 31, 0);
        do_op("sll0", 4'b0100, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 0, 0);
        do_op("sll3", 4'b0100, 32'h8000_0001, 32'd3, 32'h0000_0008, 1'b0, 3, 0);
        do_op("xor_stall", 4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 0, 5);
        do_op("illegal", 4'b1100, 32'h1111_1111, 32'h2222_2222, 32'd0, 1'b1, 0, 0);
        do_op("and_clear", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 0, 0);

        // Reset in the middle of a long shift: nothing may come out.
        @(negedge clk);
        in_valid = 1'b1; op = 4'b0100; a = 32'd1; b = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_mid_result", result, 32'd0);
        check_eq("rst_mid_zero", {31'd0, zero}, 32'd1);
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check_eq("rst_mid_no_output", 32'(vcount), 32'd0);
        $display("txn reset_mid_shift out_valid_cycles=%0d", vcount);

        // Reset coinciding with an accept drops the request.
        @(negedge clk);
        in_valid = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd2; rst = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check_eq("rst_accept_dropped", 32'(vcount), 32'd0);
        check_eq("rst_accept_in_ready", {31'd0, in_ready}, 32'd1);
        $display("txn reset_with_accept out_valid_cycles=%0d", vcount);

        for (int i = 0; i < 10; i++) begin
            r_op = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            m = alu_model(r_op, ra, rb);
            do_op("rand", r_op, ra, rb, m.res, m.ill, m.lat, (i % 3 == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
